// File: rtl/clause_serializer_if.sv
// Handshake bundle between the clause table, the serializer and the clause evaluator.
// The serializer is the slave; the requester/table/evaluator environment is the master.
interface clause_serializer_if #(
   parameter int CLAUSE_COUNT           = 20,
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int NSAT                   = 3
) ();
   localparam int LIT_W    = VARIABLE_ADDRESS_WIDTH + 1;
   localparam int CLAUSE_W = LIT_W * (NSAT - 1);
   localparam int CT_WIDTH = CLAUSE_W * CLAUSE_COUNT;
   localparam int SLOT_W   = $clog2(CLAUSE_COUNT);

   logic                              req_valid_i;
   logic                              req_ready_o;
   logic [VARIABLE_ADDRESS_WIDTH-1:0] req_index_i;
   logic [CLAUSE_COUNT-1:0]           req_mask_i;
   logic [VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_o;
   logic [CT_WIDTH-1:0]               clauses_i;
   logic                              out_valid_o;
   logic                              out_ready_i;
   logic [CLAUSE_W-1:0]               out_clause_o;
   logic [SLOT_W-1:0]                 out_slot_o;
   logic                              out_last_o;
   logic                              done_o;

   modport slave (
      input  req_valid_i, req_index_i, req_mask_i, clauses_i, out_ready_i,
      output req_ready_o, rd_addr_o, out_valid_o, out_clause_o, out_slot_o, out_last_o, done_o
   );

   modport master (
      output req_valid_i, req_index_i, req_mask_i, clauses_i, out_ready_i,
      input  req_ready_o, rd_addr_o, out_valid_o, out_clause_o, out_slot_o, out_last_o, done_o
   );
endinterface

// File: rtl/clause_serializer.sv
// Fetches one packed clause-table row and streams out the mask-enabled slots,
// lowest slot first, one per accepted handshake.
module clause_serializer #(
   parameter int CLAUSE_COUNT           = 20,
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int NSAT                   = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   clause_serializer_if.slave  bus
);
   localparam int LIT_W    = VARIABLE_ADDRESS_WIDTH + 1;
   localparam int CLAUSE_W = LIT_W * (NSAT - 1);
   localparam int CT_WIDTH = CLAUSE_W * CLAUSE_COUNT;
   localparam int SLOT_W   = $clog2(CLAUSE_COUNT);
   localparam int VAW      = VARIABLE_ADDRESS_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT} state_e;

   state_e                  state_q, state_d;
   logic [VAW-1:0]          idx_q;
   logic [CLAUSE_COUNT-1:0] mask_q;
   logic [CT_WIDTH-1:0]     row_q;
   logic                    done_q, done_d;

   logic [CLAUSE_COUNT-1:0] sel_oh;
   logic [SLOT_W-1:0]       sel;
   logic                    last;
   logic                    req_fire, out_fire;

   // Isolate the lowest pending slot; the loop runs high-to-low so the lowest set bit wins.
   assign sel_oh = mask_q & (~mask_q + CLAUSE_COUNT'(1));
   assign last   = (mask_q & (mask_q - CLAUSE_COUNT'(1))) == '0;

   always_comb begin
      sel = '0;
      for (int k = CLAUSE_COUNT - 1; k >= 0; k--)
         if (mask_q[k]) sel = SLOT_W'(k);
   end

   always_comb begin
      state_d         = state_q;
      done_d          = 1'b0;
      bus.req_ready_o = 1'b0;
      bus.out_valid_o = 1'b0;
      req_fire        = 1'b0;
      out_fire        = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready_o = 1'b1;
            if (bus.req_valid_i) begin
               req_fire = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mask_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            bus.out_valid_o = 1'b1;
            if (bus.out_ready_i) begin
               out_fire = 1'b1;
               if (last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         mask_q <= '0;
         row_q  <= '0;
      end else begin
         if (req_fire) begin
            idx_q  <= bus.req_index_i;
            mask_q <= bus.req_mask_i;
         end
         if (state_q == S_FETCH) row_q <= bus.clauses_i;
         if (out_fire) mask_q <= mask_q & ~sel_oh;
      end
   end

   // The table sees the live request index in IDLE so its registered read lands in FETCH.
   assign bus.rd_addr_o    = (state_q == S_IDLE) ? bus.req_index_i : idx_q;
   assign bus.out_clause_o = row_q[sel*CLAUSE_W +: CLAUSE_W];
   assign bus.out_slot_o   = sel;
   assign bus.out_last_o   = (state_q == S_EMIT) && last;
   assign bus.done_o       = done_q;
endmodule

// File: tb/tb_clause_serializer.sv
// Directed bench for clause_serializer: registered clause-table model, scoreboard
// queue filled at request issue and drained by an output monitor.
module tb_clause_serializer;
   localparam int CC       = 20;
   localparam int VAW      = 11;
   localparam int NSAT     = 3;
   localparam int LIT_W    = VAW + 1;
   localparam int CLAUSE_W = LIT_W * (NSAT - 1);
   localparam int CT_WIDTH = CLAUSE_W * CC;
   localparam int SLOT_W   = $clog2(CC);

   typedef struct packed {
      logic [CLAUSE_W-1:0] clause;
      logic [SLOT_W-1:0]   slot;
      logic                last;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   clause_serializer_if #(.CLAUSE_COUNT(CC), .VARIABLE_ADDRESS_WIDTH(VAW), .NSAT(NSAT)) ifc ();

   clause_serializer #(.CLAUSE_COUNT(CC), .VARIABLE_ADDRESS_WIDTH(VAW), .NSAT(NSAT)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (ifc.slave)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   function automatic logic [CLAUSE_W-1:0] slot_val(input int r, input int k);
      if (r == 5 && k == 2) return 24'h00A801;
      return CLAUSE_W'(r * 24'h010101 + k * 24'h000123 + 24'h800000);
   endfunction

   function automatic logic [CT_WIDTH-1:0] row_val(input int r);
      logic [CT_WIDTH-1:0] v;
      for (int k = 0; k < CC; k++) v[k*CLAUSE_W +: CLAUSE_W] = slot_val(r, k);
      return v;
   endfunction

   // Clause table: one-cycle registered read.
   always @(posedge clk_i) ifc.clauses_i <= row_val(int'(ifc.rd_addr_o));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every accepted output against the scoreboard and checks hold under stall.
   exp_t held;
   logic stalled = 1'b0;
   always @(negedge clk_i) begin
      if (ifc.out_valid_o && stalled) begin
         chk("hold_clause", 32'(ifc.out_clause_o), 32'(held.clause));
         chk("hold_slot", 32'(ifc.out_slot_o), 32'(held.slot));
         chk("hold_last", 32'(ifc.out_last_o), 32'(held.last));
      end
      if (ifc.out_valid_o && ifc.out_ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'(ifc.out_valid_o), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_clause", 32'(ifc.out_clause_o), 32'(e.clause));
            chk("out_slot", 32'(ifc.out_slot_o), 32'(e.slot));
            chk("out_last", 32'(ifc.out_last_o), 32'(e.last));
         end
      end
      stalled = ifc.out_valid_o && !ifc.out_ready_i;
      held    = '{ifc.out_clause_o, ifc.out_slot_o, ifc.out_last_o};
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Presents a request in cycle 0, queues its expected clauses, returns in cycle 1.
   task automatic issue(input int idx, input logic [CC-1:0] mask);
      ifc.req_valid_i = 1'b1;
      ifc.req_index_i = VAW'(idx);
      ifc.req_mask_i  = mask;
      for (int k = 0; k < CC; k++)
         if (mask[k]) sb.push_back('{slot_val(idx, k), SLOT_W'(k), (mask >> (k + 1)) == '0});
      @(negedge clk_i);
      chk("req_ready_idle", 32'(ifc.req_ready_o), 32'd1);
      chk("rd_addr_idle", 32'(ifc.rd_addr_o), 32'(idx));
      cyc();
      ifc.req_valid_i = 1'b0;
      ifc.req_index_i = '0;
      ifc.req_mask_i  = '0;
   endtask

   // Starting inside cycle 'start', waits for done_o and checks the cycle it appears in.
   task automatic wait_done(input int start, input int exp_cyc);
      int n = start;
      bit seen = 1'b0;
      while (n < start + 30 && !seen) begin
         @(negedge clk_i);
         if (ifc.done_o) begin
            seen = 1'b1;
            chk("done_cycle", 32'(n), 32'(exp_cyc));
            chk("req_ready_at_done", 32'(ifc.req_ready_o), 32'd1);
         end
         cyc();
         n++;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk_i);
      chk("done_one_cycle", 32'(ifc.done_o), 32'd0);
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.req_valid_i = 1'b1;
      ifc.req_index_i = VAW'(3);
      ifc.req_mask_i  = CC'(20'hFFFFF);
      ifc.out_ready_i = 1'b1;
      rst_ni          = 1'b0;

      // 1: reset with a request pending
      repeat (3) begin
         @(negedge clk_i);
         chk("rst_out_valid", 32'(ifc.out_valid_o), 32'd0);
         chk("rst_done", 32'(ifc.done_o), 32'd0);
      end
      cyc();
      rst_ni          = 1'b1;
      ifc.req_valid_i = 1'b0;
      ifc.req_mask_i  = '0;
      @(negedge clk_i);
      chk("ready_after_rst", 32'(ifc.req_ready_o), 32'd1);
      cyc();

      // 2: single slot, first clause two cycles after acceptance
      issue(5, CC'(20'h00004));
      @(negedge clk_i);
      chk("t2_c1_valid", 32'(ifc.out_valid_o), 32'd0);
      chk("t2_c1_rd_addr", 32'(ifc.rd_addr_o), 32'd5);
      chk("t2_c1_ready", 32'(ifc.req_ready_o), 32'd0);
      cyc();
      @(negedge clk_i);
      chk("t2_c2_valid", 32'(ifc.out_valid_o), 32'd1);
      chk("t2_c2_slot", 32'(ifc.out_slot_o), 32'd2);
      chk("t2_c2_clause", 32'(ifc.out_clause_o), 32'h00A801);
      chk("t2_c2_last", 32'(ifc.out_last_o), 32'd1);
      chk("t2_c2_rd_addr", 32'(ifc.rd_addr_o), 32'd5);
      cyc();
      wait_done(3, 3);

      // 3: slots 0,4,19 back to back
      issue(9, CC'(20'h80011));
      wait_done(1, 5);

      // 4: backpressure cycles 2-4
      ifc.out_ready_i = 1'b0;
      issue(12, CC'(20'h00003));
      cyc();
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk_i);
         chk("t4_stall_valid", 32'(ifc.out_valid_o), 32'd1);
         chk("t4_stall_slot", 32'(ifc.out_slot_o), 32'd0);
         chk("t4_stall_last", 32'(ifc.out_last_o), 32'd0);
         cyc();
      end
      ifc.out_ready_i = 1'b1;
      wait_done(5, 7);

      // 5: empty mask drains without output
      issue(2, CC'(0));
      wait_done(1, 2);

      // 6: reset after one of three slots
      issue(4, CC'(20'h00007));
      sb.delete(1);
      sb.delete(1);
      cyc();
      @(negedge clk_i);
      chk("t6_first_valid", 32'(ifc.out_valid_o), 32'd1);
      cyc();
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid_drop", 32'(ifc.out_valid_o), 32'd0);
      @(negedge clk_i);
      chk("t6_rst_done", 32'(ifc.done_o), 32'd0);
      cyc();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("t6_no_resume", 32'(ifc.out_valid_o), 32'd0);
      cyc();
      issue(7, CC'(20'h00008));
      cyc();
      @(negedge clk_i);
      chk("t6_new_slot", 32'(ifc.out_slot_o), 32'd3);
      chk("t6_new_clause", 32'(ifc.out_clause_o), 32'(slot_val(7, 3)));
      cyc();
      wait_done(3, 3);

      repeat (2) cyc();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
